seg_display_arbiter: RTL and testbench
======================================

# seg_display_arbiter

Shares the four-digit seven-segment display between two requesters: a low-priority background source (e.g. the free-running seconds count) and a high-priority alert source. It sits directly upstream of the display scan/decode controller. It grants ownership with a request/grant handshake, enforces a minimum hold time per owner, and prevents starvation of the low-priority source. It presents one registered 16-bit four-digit BCD value, a per-digit blank mask, and a valid flag.

## Interface
- HOLD_CYCLES, 50_000_000: minimum cycles an owner keeps the display (0.5 s at 100 MHz); ≥2
- MAX_CYCLES, 300_000_000: cycles after which source 1 yields to a pending source 0 (3 s); > HOLD_CYCLES
- CNT_W, 29: ownership counter width; 2^CNT_W > MAX_CYCLES

- clock_100Mhz  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- req  in  2  request; req[0] background, req[1] alert (higher priority)
- data0  in  16  source 0 digits, [15:12] thousands … [3:0] units, BCD
- data1  in  16  source 1 digits, same packing
- blank0  in  4  source 0 per-digit blank, bit 3 = thousands
- blank1  in  4  source 1 per-digit blank
- grant  out  2  one-hot owner, or 2'b00 when idle
- disp_num  out  16  BCD to display controller
- disp_blank  out  4  blank mask to display controller, 1 = digit dark
- disp_valid  out  1  high while any source owns the display
- bcd_err  out  1  one-cycle pulse: a non-BCD nibble was captured

## Operation
- States: IDLE, OWN0, OWN1. cnt = cycles since current grant asserted; 0 in the first grant cycle; saturates at MAX_CYCLES-1. hold_met = cnt ≥ HOLD_CYCLES-1. max_hit = cnt == MAX_CYCLES-1.
- IDLE: req[1] → OWN1; else req[0] → OWN0; else stay. Both requests → OWN1.
- OWN0: req[1] && hold_met → OWN1. Else !req[0] && hold_met → IDLE. Else stay.
- OWN1:
  - req[0] && max_hit → OWN0 (fairness).
  - Else !req[1] && hold_met → OWN0 if req[0], otherwise IDLE.
  - Else stay.
- Every ownership change, including a direct OWNx→OWNy switch, clears cnt to 0. Direct switches insert no idle cycle.
- Owner drops req before hold_met: grant stays high until hold_met. disp_num and disp_blank stay frozen at the last captured values.
- Capture: while in OWNx with req[x]=1, disp_num/disp_blank load dataX/blankX every cycle. On the entry edge, the winner's inputs of that cycle are loaded.
- Sanitize: any captured nibble >9 is replaced by 4'h0. bcd_err pulses on that same edge. Each offending capture gives one pulse; consecutive bad captures give consecutive pulses.
- IDLE: disp_valid=0, disp_blank=4'b1111, disp_num holds its last value.

## Timing
- Reset values: state IDLE, cnt 0, grant 2'b00, disp_num 16'h0000, disp_blank 4'b1111, disp_valid 0, bcd_err 0.
- Reset overrides everything on the same edge, including mid-ownership. There is no pending state afterwards; requests are re-arbitrated from IDLE on the next edge.
- All outputs are registered.
- Grant latency: req sampled high at edge N → grant, disp_num, disp_blank and disp_valid valid after edge N.
- Minimum grant width: HOLD_CYCLES cycles, unless reset intervenes.
- Data follow-through while owning: 1 cycle.
- Release: hold_met && !req[x] in cycle k → grant changes after edge k.
- Preemption of OWN0: at earliest, the grant for source 1 is visible HOLD_CYCLES cycles after the OWN0 grant was first visible.

## Structure
- Package seg_disp_pkg holds:
  - state encoding (ST_IDLE, ST_OWN0, ST_OWN1)
  - source indices SRC_BG=0 and SRC_ALERT=1
  - BLANK_ALL=4'b1111
  - BCD_MAX=4'd9
- Sub-module seg_hold_timer contains the CNT_W saturating counter with a sync clear and the hold_met/max_hit compares. The FSM, capture and sanitize logic stay in seg_display_arbiter.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=4, MAX_CYCLES=10, CNT_W=5.
- Reset: assert reset 2 cycles with req=2'b11 → grant 00, disp_blank 1111, disp_valid 0, disp_num 0000. After release, grant=10 one cycle later.
- Short request: req0 pulsed 1 cycle with data0=16'h1234, blank0=4'b1000 → grant 01 for exactly 4 cycles, disp_num 1234, disp_blank 1000. Then grant 00, disp_blank 1111, disp_valid 0.
- Preemption: OWN0 established; req1 rises at cnt=1 with data1=16'h0042 → grant 10 appears after cnt=3, disp_num 0042, with no idle cycle between.
- Starvation: req=2'b11 held continuously → grant 10 for 10 cycles, then 01 for 4 cycles, then 10 again, repeating.
- Bad BCD: owning source 0, data0=16'h12A4 → disp_num 1204 and bcd_err high for one cycle. Then data0=16'h1204 → bcd_err 0.
- Mid-ownership reset: reset in OWN1 at cnt=2 → next edge gives reset values. With req1 still high, grant 10 returns one cycle after reset falls, with cnt restarting at 0.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared encodings and constants for the seven-segment display arbiter.
// Imported by the arbiter top and its hold timer.
package seg_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam int SRC_BG    = 0;
    localparam int SRC_ALERT = 1;

    localparam logic [3:0] BLANK_ALL = 4'b1111;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // One-hot grant vector for a given owner state; idle maps to 2'b00.
    function automatic logic [1:0] state_grant(input state_t s);
        logic [1:0] g;
        g = 2'b00;
        if (s == ST_OWN0) g[SRC_BG]    = 1'b1;
        if (s == ST_OWN1) g[SRC_ALERT] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/seg_hold_timer.sv
// Ownership age counter: saturating, synchronously clearable, with the
// minimum-hold and fairness-limit compares taken from the registered count.
module seg_hold_timer
    import seg_disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int MAX_CYCLES  = 300_000_000,
    parameter int CNT_W       = 29
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    output logic hold_met,
    output logic max_hit
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hold_met = (cnt_q >= HOLD_LAST);
    assign max_hit  = (cnt_q == MAX_LAST);

endmodule

// File: rtl/seg_display_arbiter.sv
// Two-source arbiter for the four-digit BCD display: alert preempts background
// after a minimum hold, background is guaranteed a turn after the fairness limit.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int MAX_CYCLES  = 300_000_000,
    parameter int CNT_W       = 29
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [3:0]  blank0,
    input  logic [3:0]  blank1,
    output logic [1:0]  grant,
    output logic [15:0] disp_num,
    output logic [3:0]  disp_blank,
    output logic        disp_valid,
    output logic        bcd_err
);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] disp_num_q, disp_num_d;
    logic [3:0]  disp_blank_q, disp_blank_d;
    logic        disp_valid_q, disp_valid_d;
    logic        bcd_err_q, bcd_err_d;

    logic        hold_met;
    logic        max_hit;
    logic        timer_clr;
    logic        cap_en;
    logic [15:0] cap_data;
    logic [3:0]  cap_blank;
    logic [15:0] cap_clean;
    logic [3:0]  nib_bad;

    seg_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_timer (
        .clk      (clock_100Mhz),
        .srst     (reset),
        .clr      (timer_clr),
        .hold_met (hold_met),
        .max_hit  (max_hit)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req[SRC_ALERT])   state_d = ST_OWN1;
                else if (req[SRC_BG]) state_d = ST_OWN0;
            end
            ST_OWN0: begin
                if (req[SRC_ALERT] && hold_met)    state_d = ST_OWN1;
                else if (!req[SRC_BG] && hold_met) state_d = ST_IDLE;
            end
            ST_OWN1: begin
                if (req[SRC_BG] && max_hit)           state_d = ST_OWN0;
                else if (!req[SRC_ALERT] && hold_met) state_d = req[SRC_BG] ? ST_OWN0 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Any ownership change restarts the age; idle keeps it parked at zero.
    assign timer_clr = (state_d != state_q) || (state_d == ST_IDLE);

    // Capture follows the next owner, so the entry edge loads the winner's data.
    assign cap_en    = ((state_d == ST_OWN0) && req[SRC_BG]) ||
                       ((state_d == ST_OWN1) && req[SRC_ALERT]);
    assign cap_data  = (state_d == ST_OWN1) ? data1  : data0;
    assign cap_blank = (state_d == ST_OWN1) ? blank1 : blank0;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sanitize
        assign nib_bad[gi]           = (cap_data[gi*4 +: 4] > BCD_MAX);
        assign cap_clean[gi*4 +: 4]  = nib_bad[gi] ? 4'h0 : cap_data[gi*4 +: 4];
    end

    always_comb begin
        grant_d      = state_grant(state_d);
        disp_valid_d = (state_d != ST_IDLE);
        disp_num_d   = cap_en ? cap_clean : disp_num_q;
        bcd_err_d    = cap_en && (|nib_bad);
        disp_blank_d = disp_blank_q;
        if (state_d == ST_IDLE) begin
            disp_blank_d = BLANK_ALL;
        end else if (cap_en) begin
            disp_blank_d = cap_blank;
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            disp_num_q   <= 16'h0000;
            disp_blank_q <= BLANK_ALL;
            disp_valid_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            disp_num_q   <= disp_num_d;
            disp_blank_q <= disp_blank_d;
            disp_valid_q <= disp_valid_d;
            bcd_err_q    <= bcd_err_d;
        end
    end

    assign grant      = grant_q;
    assign disp_num   = disp_num_q;
    assign disp_blank = disp_blank_q;
    assign disp_valid = disp_valid_q;
    assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter with short hold/limit parameters: directed
// vector table, hand-written multi-cycle sequences, and randomized traffic.
module tb_seg_display_arbiter;

    localparam int HOLD = 4;
    localparam int MAXC = 10;

    logic        clock_100Mhz;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] data0, data1;
    logic [3:0]  blank0, blank1;
    logic [1:0]  grant;
    logic [15:0] disp_num;
    logic [3:0]  disp_blank;
    logic        disp_valid;
    logic        bcd_err;

    seg_display_arbiter #(
        .HOLD_CYCLES (HOLD),
        .MAX_CYCLES  (MAXC),
        .CNT_W       (5)
    ) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .req          (req),
        .data0        (data0),
        .data1        (data1),
        .blank0       (blank0),
        .blank1       (blank1),
        .grant        (grant),
        .disp_num     (disp_num),
        .disp_blank   (disp_blank),
        .disp_valid   (disp_valid),
        .bcd_err      (bcd_err)
    );

    initial begin
        clock_100Mhz = 1'b0;
        forever #5 clock_100Mhz = ~clock_100Mhz;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // Reference model: owner is -1 (nobody), 0 or 1; age counts cycles owned.
    int          m_owner = -1;
    int          m_age   = 0;
    logic [15:0] m_num   = 16'h0000;
    logic [3:0]  m_blank = 4'b1111;
    logic        m_err   = 1'b0;

    function automatic logic [15:0] decimal_clean(input logic [15:0] d, output logic bad);
        int v;
        int digit;
        int res;
        v = int'(d);
        res = 0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            digit = (v / (16 ** k)) % 16;
            if (digit > 9) begin
                bad = 1'b1;
                digit = 0;
            end
            res = res + digit * (16 ** k);
        end
        return 16'(res);
    endfunction

    task automatic model_step();
        int  nxt;
        bit  held_long;
        bit  at_limit;
        logic bad;
        logic [15:0] cleaned;
        if (reset) begin
            m_owner = -1; m_age = 0; m_num = 16'h0000; m_blank = 4'b1111; m_err = 1'b0;
            return;
        end
        held_long = (m_age >= HOLD - 1);
        at_limit  = (m_age == MAXC - 1);
        nxt = m_owner;
        if (m_owner == -1) begin
            if (req[1]) nxt = 1;
            else if (req[0]) nxt = 0;
        end else if (m_owner == 0) begin
            if (req[1] && held_long) nxt = 1;
            else if (!req[0] && held_long) nxt = -1;
        end else begin
            if (req[0] && at_limit) nxt = 0;
            else if (!req[1] && held_long) nxt = req[0] ? 0 : -1;
        end
        if (nxt != m_owner || nxt == -1) m_age = 0;
        else if (m_age < MAXC - 1) m_age = m_age + 1;
        m_owner = nxt;
        m_err = 1'b0;
        if (m_owner == -1) begin
            m_blank = 4'b1111;
        end else if (req[m_owner]) begin
            cleaned = decimal_clean(m_owner == 1 ? data1 : data0, bad);
            m_num   = cleaned;
            m_blank = (m_owner == 1) ? blank1 : blank0;
            m_err   = bad;
        end
    endtask

    function automatic logic [1:0] model_grant();
        if (m_owner == 1) return 2'b10;
        if (m_owner == 0) return 2'b01;
        return 2'b00;
    endfunction

    int tick_no = 0;

    // Drive one cycle of inputs, clock it, and compare DUT against the model.
    task automatic tick(input logic r, input logic [1:0] q,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [3:0] c0, input logic [3:0] c1);
        reset = r; req = q; data0 = a0; data1 = a1; blank0 = c0; blank1 = c1;
        model_step();
        @(posedge clock_100Mhz);
        #1;
        tick_no++;
        chk($sformatf("model grant t%0d", tick_no),  32'(grant),      32'(model_grant()));
        chk($sformatf("model num t%0d", tick_no),    32'(disp_num),   32'(m_num));
        chk($sformatf("model blank t%0d", tick_no),  32'(disp_blank), 32'(m_blank));
        chk($sformatf("model valid t%0d", tick_no),  32'(disp_valid), 32'(m_owner != -1));
        chk($sformatf("model bcderr t%0d", tick_no), 32'(bcd_err),    32'(m_err));
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  rq;
        logic [15:0] d0;
        logic [3:0]  b0;
        logic [1:0]  g;
        logic [15:0] num;
        logic [3:0]  blk;
        logic        v;
        logic        e;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [1:0] rq, input logic [15:0] d0,
                                input logic [3:0] b0, input logic [1:0] g, input logic [15:0] num,
                                input logic [3:0] blk, input logic v, input logic e);
        vec_t x;
        x.rst = rst; x.rq = rq; x.d0 = d0; x.b0 = b0;
        x.g = g; x.num = num; x.blk = blk; x.v = v; x.e = e;
        return x;
    endfunction

    vec_t vecs[18];

    logic [1:0]  rreq;
    logic [15:0] rd0, rd1;
    logic        rrst;

    function automatic logic [15:0] rand_data();
        logic [15:0] d;
        if ($urandom_range(0, 1) == 0) begin
            d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end else begin
            d = 16'($urandom);
        end
        return d;
    endfunction

    initial begin
        reset = 1'b1; req = 2'b00; data0 = '0; data1 = '0; blank0 = '0; blank1 = '0;

        // data1 = 5678, blank1 = 0000 throughout the table
        vecs[0]  = mk(1, 2'b11, 16'h0000, 4'b0000, 2'b00, 16'h0000, 4'b1111, 0, 0);
        vecs[1]  = mk(1, 2'b11, 16'h0000, 4'b0000, 2'b00, 16'h0000, 4'b1111, 0, 0);
        vecs[2]  = mk(0, 2'b11, 16'h0000, 4'b0000, 2'b10, 16'h5678, 4'b0000, 1, 0);
        vecs[3]  = mk(0, 2'b00, 16'h0000, 4'b0000, 2'b10, 16'h5678, 4'b0000, 1, 0);
        vecs[4]  = mk(0, 2'b00, 16'h0000, 4'b0000, 2'b10, 16'h5678, 4'b0000, 1, 0);
        vecs[5]  = mk(0, 2'b00, 16'h0000, 4'b0000, 2'b10, 16'h5678, 4'b0000, 1, 0);
        vecs[6]  = mk(0, 2'b00, 16'h0000, 4'b0000, 2'b00, 16'h5678, 4'b1111, 0, 0);
        vecs[7]  = mk(0, 2'b01, 16'h1234, 4'b1000, 2'b01, 16'h1234, 4'b1000, 1, 0);
        vecs[8]  = mk(0, 2'b00, 16'h9999, 4'b0001, 2'b01, 16'h1234, 4'b1000, 1, 0);
        vecs[9]  = mk(0, 2'b00, 16'h9999, 4'b0001, 2'b01, 16'h1234, 4'b1000, 1, 0);
        vecs[10] = mk(0, 2'b00, 16'h9999, 4'b0001, 2'b01, 16'h1234, 4'b1000, 1, 0);
        vecs[11] = mk(0, 2'b00, 16'h9999, 4'b0001, 2'b00, 16'h1234, 4'b1111, 0, 0);
        vecs[12] = mk(0, 2'b01, 16'h12A4, 4'b0000, 2'b01, 16'h1204, 4'b0000, 1, 1);
        vecs[13] = mk(0, 2'b01, 16'h1204, 4'b0000, 2'b01, 16'h1204, 4'b0000, 1, 0);
        vecs[14] = mk(0, 2'b01, 16'hFA9B, 4'b0010, 2'b01, 16'h0090, 4'b0010, 1, 1);
        vecs[15] = mk(0, 2'b01, 16'hC000, 4'b0010, 2'b01, 16'h0000, 4'b0010, 1, 1);
        vecs[16] = mk(0, 2'b01, 16'h0987, 4'b0000, 2'b01, 16'h0987, 4'b0000, 1, 0);
        vecs[17] = mk(0, 2'b00, 16'h0987, 4'b0000, 2'b00, 16'h0987, 4'b1111, 0, 0);

        for (int i = 0; i < 18; i++) begin
            tick(vecs[i].rst, vecs[i].rq, vecs[i].d0, 16'h5678, vecs[i].b0, 4'b0000);
            chk($sformatf("vec%0d grant", i), 32'(grant),      32'(vecs[i].g));
            chk($sformatf("vec%0d num", i),   32'(disp_num),   32'(vecs[i].num));
            chk($sformatf("vec%0d blank", i), 32'(disp_blank), 32'(vecs[i].blk));
            chk($sformatf("vec%0d valid", i), 32'(disp_valid), 32'(vecs[i].v));
            chk($sformatf("vec%0d bcderr", i), 32'(bcd_err),   32'(vecs[i].e));
            $display("vec%0d rst=%b req=%b d0=%h -> grant=%b num=%h blank=%b valid=%b err=%b",
                     i, vecs[i].rst, vecs[i].rq, vecs[i].d0, grant, disp_num, disp_blank,
                     disp_valid, bcd_err);
        end

        // Preemption: req1 rises while OWN0 is at age 1; switch lands after age 3 with no gap.
        tick(1, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000);
        tick(0, 2'b01, 16'h1111, 16'h0042, 4'b0000, 4'b0000);
        chk("preempt own0 t0", 32'(grant), 32'(2'b01));
        tick(0, 2'b01, 16'h1111, 16'h0042, 4'b0000, 4'b0000);
        chk("preempt own0 t1", 32'(grant), 32'(2'b01));
        for (int i = 2; i < 4; i++) begin
            tick(0, 2'b11, 16'h1111, 16'h0042, 4'b0000, 4'b0000);
            chk($sformatf("preempt hold t%0d", i), 32'(grant), 32'(2'b01));
        end
        tick(0, 2'b11, 16'h1111, 16'h0042, 4'b0000, 4'b0000);
        chk("preempt switch grant", 32'(grant), 32'(2'b10));
        chk("preempt switch num", 32'(disp_num), 32'(16'h0042));
        chk("preempt switch valid", 32'(disp_valid), 32'(1'b1));
        $display("preemption sequence: grant=%b num=%h", grant, disp_num);

        // Starvation: both held; 10 cycles alert, 4 cycles background, repeating.
        tick(1, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 28; i++) begin
            tick(0, 2'b11, 16'h0007, 16'h0009, 4'b0000, 4'b0000);
            chk($sformatf("starve c%0d", i), 32'(grant),
                32'(((i % 14) < 10) ? 2'b10 : 2'b01));
        end
        $display("starvation sequence: 28 cycles, final grant=%b", grant);

        // Reset mid OWN1 at age 2, then re-grant from a fresh age.
        tick(1, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) tick(0, 2'b10, 16'h0000, 16'h0321, 4'b0000, 4'b0100);
        tick(1, 2'b10, 16'h0000, 16'h0321, 4'b0000, 4'b0100);
        chk("midrst grant", 32'(grant), 32'(2'b00));
        chk("midrst num", 32'(disp_num), 32'(16'h0000));
        chk("midrst blank", 32'(disp_blank), 32'(4'b1111));
        chk("midrst valid", 32'(disp_valid), 32'(1'b0));
        tick(0, 2'b10, 16'h0000, 16'h0321, 4'b0000, 4'b0100);
        chk("midrst regrant", 32'(grant), 32'(2'b10));
        for (int i = 0; i < 4; i++) begin
            tick(0, 2'b00, 16'h0000, 16'h0321, 4'b0000, 4'b0100);
            chk($sformatf("midrst hold%0d", i), 32'(grant), 32'((i < 3) ? 2'b10 : 2'b00));
        end
        $display("mid-ownership reset sequence: final grant=%b", grant);

        // Randomized traffic against the model.
        rreq = 2'b00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rreq = 2'($urandom);
            rrst = ($urandom_range(0, 63) == 0);
            rd0 = rand_data();
            rd1 = rand_data();
            tick(rrst, rreq, rd0, rd1, 4'($urandom), 4'($urandom));
        end
        $display("randomized phase: 600 cycles");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
